fxyz_table_scanner: RTL

Sequential stimulus-and-capture stage sitting directly upstream of the 3-input combinational function block fxyz, where s = (~y & z) | (x & y).
- On a start request it drives x,y,z through all 8 combinations in order 000..111 and lets each settle.
- It samples s for each combination and assembles the measured 8-bit truth table.
- It compares the table against a parameterised expected table and reports pass/fail plus a mismatch count.
- Replaces hand-written #10 stimulus sequences with a synthesizable self-checking scanner.

---
 rtl/fxyz_table_scanner.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fxyz_table_scanner.sv
// Drives x,y,z through all eight input combinations of the fxyz block, samples s after a
// settle window, and reports the measured truth table against an expected one.
module fxyz_table_scanner #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [7:0]  EXPECTED = 8'hE2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       s,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic [3:0] err_count,
  output logic       match
);

  localparam logic [3:0] WaitLoad = 4'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] wait_q, wait_d;
  logic [7:0] table_q, table_d;
  logic [3:0] err_q, err_d;
  logic       match_q, match_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StSettle;
      StSettle: if (wait_q == 4'd0) state_d = StSample;
      StSample: state_d = (idx_q == 3'd7) ? StDone : StSettle;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  assign x         = vec_q[2];
  assign y         = vec_q[1];
  assign z         = vec_q[0];
  assign table_out = table_q;
  assign err_count = err_q;
  assign match     = match_q;

  always_comb begin
    idx_d   = idx_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    table_d = table_q;
    err_d   = err_q;
    match_d = match_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          table_d = 8'h00;
          err_d   = 4'd0;
          idx_d   = 3'd0;
          vec_d   = 3'd0;
          wait_d  = WaitLoad;
        end
      end
      StSettle: begin
        if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
      end
      StSample: begin
        table_d[idx_q] = s;
        if (s != EXPECTED[idx_q]) err_d = err_q + 4'd1;
        if (idx_q != 3'd7) begin
          idx_d  = idx_q + 3'd1;
          vec_d  = idx_q + 3'd1;
          wait_d = WaitLoad;
        end
      end
      StDone: begin
        // err_q already holds the final bit's contribution here
        match_d = (err_q == 4'd0);
        vec_d   = 3'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= 3'd0;
      vec_q   <= 3'd0;
      wait_q  <= 4'd0;
      table_q <= 8'h00;
      err_q   <= 4'd0;
      match_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      table_q <= table_d;
      err_q   <= err_d;
      match_q <= match_d;
    end
  end

endmodule
